uart_tx_fsm: RTL

//  UART transmit path: serializer, parity generator, bit mux and control FSM in one block.

---
 rtl/uart_tx_fsm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fsm.sv
// -----------------------------------------------------------------------------
// uart_tx_fsm
//
// UART transmit path: serializer, parity generator, bit mux and control FSM.
// Runs at the TX baud clock, so one CLK cycle is one bit period.
//
// Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first,
// an optional parity bit, and 1 stop bit (1).
//
// Ports
//   CLK        in   TX baud clock; all flops update on posedge
//   RST        in   synchronous, active-high reset; aborts any frame in flight
//   P_DATA     in   parallel word to send; sampled only at the accept edge
//   Data_Valid in   send request; honoured only while the block is idle
//   PAR_EN     in   1 = insert a parity bit; latched at the accept edge
//   PAR_TYP    in   0 = even, 1 = odd parity; latched at the accept edge
//   TX_OUT     out  registered serial line, idles high
//   busy       out  registered; high from the accept edge to the end of stop
// -----------------------------------------------------------------------------
module uart_tx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    // The counter must be able to hold the value DATA_WIDTH itself, which is
    // the count at which the last data bit has been placed on the line.
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_q,  state_d;
    logic                  tx_q,     tx_d;
    logic                  busy_q,   busy_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic                  par_q,    par_d;
    logic                  par_en_q, par_en_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        par_en_d = par_en_q;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid) begin
                    // Accept edge: snapshot the word and its configuration so
                    // later input changes cannot disturb this frame. Parity is
                    // computed once here from the data being latched.
                    shift_d  = P_DATA;
                    par_en_d = PAR_EN;
                    par_d    = (^P_DATA) ^ PAR_TYP;
                    tx_d     = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = START;
                end
            end

            START: begin
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = CNT_W'(1);
                state_d = DATA;
            end

            DATA: begin
                if (cnt_q == CNT_W'(DATA_WIDTH)) begin
                    if (par_en_q) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                tx_d    = 1'b1;
                state_d = STOP;
            end

            STOP: begin
                // Data_Valid is deliberately not looked at here, which
                // guarantees one idle-high cycle between back-to-back frames.
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end

            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule
